ivector_heard_monitor: RTL
==========================

// Module: ivector_heard_monitor
//
// PURPOSE
// - Downstream consumer of the IVector indication stream: accepts heard(meth, v) beats, one per cycle max.
// - Per lane: message counter and sequence check (lane values must increment by 1 from 0).
// - Forwards each beat, tagged with its per-lane sequence number, through a small buffer to the host-side msg stream.
// - Sticky error flags give a debug view of lane-dispatch correctness and of starvation (counters).
//
// PARAMETERS
// - LANES       10  number of vector lanes; valid meth range 0..LANES-1
// - IDX_WIDTH   4   width of meth / lane index
// - DATA_WIDTH  32  width of payload v
// - SEQ_WIDTH   16  width of per-lane counter and seq tag
// - DEPTH       4   output buffer entries (power of 2, >=2)
//
// PORTS
// - CLK             in   1           clock, all logic posedge
// - nRST            in   1           reset, synchronous, active-low
// - heard__ENA      in   1           upstream beat valid
// - heard__RDY      out  1           ready to accept a beat
// - heard$meth      in   IDX_WIDTH   lane index of beat
// - heard$v         in   DATA_WIDTH  payload
// - msg__ENA        out  1           output beat valid
// - msg__RDY        in   1           downstream ready
// - msg$meth        out  IDX_WIDTH   lane of head entry
// - msg$v           out  DATA_WIDTH  payload of head entry
// - msg$seq         out  SEQ_WIDTH   lane count before this beat (0 for first beat of a lane)
// - clear__ENA      in   1           clear counters, expected values, error flags
// - stat_sel        in   IDX_WIDTH   lane select for stat_count
// - stat_count      out  SEQ_WIDTH   count[stat_sel]; 0 if stat_sel >= LANES (combinational)
// - err_seq         out  1           sticky: a lane value mismatched its expected value
// - err_lane        out  IDX_WIDTH   lane of FIRST seq error since reset/clear
// - err_range       out  1           sticky: beat arrived with meth >= LANES
//
// BEHAVIOUR
// - Reset (nRST=0 at posedge): buffer empty, count[*]=0, exp[*]=0, err_seq=0, err_lane=0, err_range=0.
//   While nRST=0: heard__RDY=0, msg__ENA=0. heard__RDY=1 in the first cycle after release.
// - Accept: heard__ENA && heard__RDY. heard__RDY = !full; it never depends on heard__ENA (no comb loop).
// - Valid lane L accept: enqueue {L, v, count[L]}; count[L] saturates at all-ones; exp[L] <= v+1
//   (modulo 2^DATA_WIDTH, resyncs after error). If v != exp[L]: err_seq<=1; err_lane<=L only if err_seq was 0.
// - meth >= LANES: beat consumed, not enqueued, no counter change, err_range<=1.
// - Output: msg__ENA = !empty; fields show head entry, stable while msg__ENA && !msg__RDY.
//   Pop on msg__ENA && msg__RDY.
// - Latency: accepted beat visible on msg the next cycle if buffer was empty; no same-cycle bypass.
// - Full: heard__RDY=0. A pop while full raises heard__RDY only the next cycle.
//   Push+pop in the same cycle (not full) keeps occupancy unchanged.
// - Throughput: 1 beat/cycle sustained when msg__RDY held 1.
// - clear__ENA: next cycle count[*]=0, exp[*]=0, all err flags=0. Clear wins over a same-cycle accept's
//   counter/exp/err update. That beat is still enqueued, seq = pre-clear count. Buffer contents untouched.
// - Reset mid-stream: buffered entries discarded, no msg__ENA until new beats arrive.
//
// STRUCTURE
// - Package ivector_mon_pkg: LANES, widths, typedef struct packed {meth; v; seq} heard_msg_t.
// - Sub-module heard_fifo: generic sync FIFO (DEPTH, width of heard_msg_t), enq/deq ENA/RDY, same reset.
// - Top: per-lane count/exp register arrays, error logic, stat mux.
//
// TESTING
// - Reset release, lane 3 sends v=0,1,2 with msg__RDY=1 -> msg seq 0,1,2 one cycle later each;
//   stat_sel=3 gives stat_count=3; no errors.
// - msg__RDY=0, 5 beats offered -> 4 accepted, heard__RDY=0 from cycle 4. Raise msg__RDY ->
//   entries drained in order; 5th beat accepted one cycle after first pop.
// - Lane 7 sends 0,1,5,6 -> err_seq=1, err_lane=7 after beat v=5. Lane 2 sends 9 -> err_lane stays 7.
//   No further error on lane 7 for v=6.
// - meth=12 beat -> accepted, no msg output, err_range=1, all counts unchanged.
// - clear__ENA with same-cycle lane 0 beat (count 4) -> msg seq=4; next cycle count[0]=0, errs 0;
//   next lane 0 v=0 gives no error.
// - nRST low for 1 cycle with 3 entries buffered -> msg__ENA=0, counts 0, heard__RDY=1 after release.

Source files
------------

// File: rtl/ivector_mon_pkg.sv
// Shared sizing constants and the buffered beat format for the IVector heard-stream monitor.
package ivector_mon_pkg;

  localparam int LANES      = 10;
  localparam int IDX_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;
  localparam int SEQ_WIDTH  = 16;
  localparam int DEPTH      = 4;

  typedef struct packed {
    logic [IDX_WIDTH-1:0]  meth;
    logic [DATA_WIDTH-1:0] v;
    logic [SEQ_WIDTH-1:0]  seq;
  } heard_msg_t;

endpackage

// File: rtl/heard_fifo.sv
// Generic synchronous FIFO with ENA/RDY handshakes on both sides and synchronous active-low reset.
module heard_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq_ena,
  output logic             enq_rdy,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq_ena,
  output logic             deq_rdy,
  output logic [WIDTH-1:0] deq_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign enq_rdy  = !full;
  assign deq_rdy  = !empty;
  assign push     = enq_ena && !full;
  assign pop      = deq_ena && !empty;
  assign deq_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= enq_data;
  end

endmodule

// File: rtl/ivector_heard_monitor.sv
// Consumes heard(meth, v) beats, checks per-lane sequencing and forwards seq-tagged beats to msg.
module ivector_heard_monitor
  import ivector_mon_pkg::*;
(
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  heard__ENA,
  output logic                  heard__RDY,
  input  logic [IDX_WIDTH-1:0]  heard_meth,
  input  logic [DATA_WIDTH-1:0] heard_v,
  output logic                  msg__ENA,
  input  logic                  msg__RDY,
  output logic [IDX_WIDTH-1:0]  msg_meth,
  output logic [DATA_WIDTH-1:0] msg_v,
  output logic [SEQ_WIDTH-1:0]  msg_seq,
  input  logic                  clear__ENA,
  input  logic [IDX_WIDTH-1:0]  stat_sel,
  output logic [SEQ_WIDTH-1:0]  stat_count,
  output logic                  err_seq,
  output logic [IDX_WIDTH-1:0]  err_lane,
  output logic                  err_range
);

  logic [SEQ_WIDTH-1:0]  count   [LANES];
  logic [DATA_WIDTH-1:0] exp_val [LANES];
  logic [SEQ_WIDTH-1:0]  cur_count;
  logic [DATA_WIDTH-1:0] cur_exp;
  logic                  valid_lane;
  logic                  accept;
  logic                  fifo_enq_rdy;
  logic                  fifo_deq_rdy;
  heard_msg_t            enq_msg;
  heard_msg_t            head_msg;

  // Handshakes are forced low while reset is held, whatever the buffer pointers hold.
  assign heard__RDY = nRST && fifo_enq_rdy;
  assign msg__ENA   = nRST && fifo_deq_rdy;
  assign accept     = heard__ENA && heard__RDY;
  assign valid_lane = (heard_meth < IDX_WIDTH'(LANES));

  always_comb begin
    cur_count = '0;
    cur_exp   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (heard_meth == IDX_WIDTH'(i)) begin
        cur_count = count[i];
        cur_exp   = exp_val[i];
      end
    end
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < LANES; i++) begin
      if (stat_sel == IDX_WIDTH'(i)) stat_count = count[i];
    end
  end

  assign enq_msg = '{meth: heard_meth, v: heard_v, seq: cur_count};

  heard_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(heard_msg_t))
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (nRST),
    .enq_ena  (accept && valid_lane),
    .enq_rdy  (fifo_enq_rdy),
    .enq_data (enq_msg),
    .deq_ena  (msg__ENA && msg__RDY),
    .deq_rdy  (fifo_deq_rdy),
    .deq_data (head_msg)
  );

  assign msg_meth = head_msg.meth;
  assign msg_v    = head_msg.v;
  assign msg_seq  = head_msg.seq;

  // Clear shares the reset path, so it overrides any same-cycle counter or error update.
  always_ff @(posedge CLK) begin
    if (!nRST || clear__ENA) begin
      for (int i = 0; i < LANES; i++) begin
        count[i]   <= '0;
        exp_val[i] <= '0;
      end
      err_seq   <= 1'b0;
      err_lane  <= '0;
      err_range <= 1'b0;
    end else if (accept) begin
      if (valid_lane) begin
        for (int i = 0; i < LANES; i++) begin
          if (heard_meth == IDX_WIDTH'(i)) begin
            if (count[i] != '1) count[i] <= count[i] + SEQ_WIDTH'(1);
            exp_val[i] <= heard_v + DATA_WIDTH'(1);
          end
        end
        if (heard_v != cur_exp) begin
          err_seq <= 1'b1;
          if (!err_seq) err_lane <= heard_meth;
        end
      end else begin
        err_range <= 1'b1;
      end
    end
  end

endmodule
